vga_text_writer: RTL and testbench
==================================

VGA_TEXT_WRITER -- requirements
Module: vga_text_writer

Interface
REQ-001 The parameter COLS shall default to 80 and set the number of text columns per row.
REQ-002 The parameter ROWS shall default to 32 and set the number of text rows.
REQ-003 The parameter COL_BITS shall default to 7 and set the column field width in waddr.
REQ-004 The parameter ROW_BITS shall default to 5 and set the row field width in waddr.
REQ-005 clk  input  1  single clock, 100 MHz; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 bus_we  input  1  CPU store strobe carrying one character code.
REQ-008 bus_data  input  8  character code (ASCII or control code).
REQ-009 bus_ready  output  1  high when a character can be accepted this cycle.
REQ-010 waddr  output  32  text-RAM write address {zeros, row[ROW_BITS-1:0], col[COL_BITS-1:0]}.
REQ-011 wdata  output  8  ASCII code to write.
REQ-012 selRW  output  1  one-cycle write pulse; waddr/wdata valid in the same cycle.
REQ-013 cur_row  output  ROW_BITS  current cursor row.
REQ-014 cur_col  output  COL_BITS  current cursor column.

Function
REQ-015 A character shall be accepted only in a cycle with bus_we=1 and bus_ready=1; bus_we while bus_ready=0 shall be ignored (not queued).
REQ-016 FSM states shall be IDLE, PUT, CLR_ROW, CLR_ALL; bus_ready shall be 1 only in IDLE.
REQ-017 Printable 0x20-0x7E: IDLE->PUT; in the next cycle selRW=1, wdata=code, waddr=cursor; cursor col+1; return to IDLE (acceptance to pulse latency 1 cycle).
REQ-018 Column wrap: a write at col COLS-1 shall move the cursor to col 0, row+1.
REQ-019 0x0A (LF): col=0, row+1, no write pulse.
REQ-020 0x0D (CR): col=0, row unchanged, no write pulse.
REQ-021 0x08 (BS): if col>0, col-1 and write 0x20 at the new position via PUT; if col=0, no change and no write pulse.
REQ-022 0x0C (FF): enter CLR_ALL; write 0x20 to every cell row 0..ROWS-1, col 0..COLS-1, one selRW pulse per cycle (ROWS*COLS pulses); cursor ends at (0,0).
REQ-023 Any other code shall be discarded with no write pulse and no cursor change.
REQ-024 Row wrap: when the cursor row advances past ROWS-1 it shall become 0, and CLR_ROW shall write 0x20 to all COLS cells of the new row (COLS pulses) before returning to IDLE.
REQ-025 Row advance to a row below ROWS shall not clear that row.
REQ-026 Columns COLS..2^COL_BITS-1 shall never be addressed.
REQ-027 Outside PUT/CLR_ROW/CLR_ALL, selRW shall be 0; waddr/wdata shall hold their last values.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, cursor=(0,0), selRW=0, waddr=0, wdata=0x20, bus_ready=1 the following cycle.
REQ-029 rst during CLR_ROW or CLR_ALL shall abort the clear immediately with no further write pulses.
REQ-030 rst shall have priority over a simultaneous bus_we.

Structure
REQ-031 Control code constants (0x08, 0x0A, 0x0C, 0x0D, 0x20) and COLS/ROWS defaults shall live in the shared define.v.
REQ-032 One sub-module, vga_cursor, shall hold the row/col counters with inc, newline, cr, back, and home controls.
REQ-033 The block's waddr/wdata/selRW shall connect directly to the matching vga_controller inputs.

Verification
REQ-034 Reset, then send 'A' (0x41) -> one selRW pulse, waddr=0x000, wdata=0x41; cursor=(0,1).
REQ-035 Send 80 x 'B' from (0,0) -> 80 pulses, last waddr=0x04F; cursor=(1,0).
REQ-036 Cursor (31,5), send 0x0A -> cursor (0,0); 80 pulses of 0x20 at waddr 0x000-0x04F; bus_ready=0 throughout.
REQ-037 Cursor (3,10), send 0x08 -> one pulse waddr={3,9}=0x189, wdata=0x20; cursor (3,9); at col 0, 0x08 -> no pulse.
REQ-038 Send 0x0C -> exactly 2560 pulses of 0x20; assert rst at pulse 100 -> no further pulses, cursor (0,0).
REQ-039 bus_we held high with 'C' during CLR_ROW -> characters ignored; first accepted only once bus_ready=1.

Source files
------------

// File: rtl/vga_text_writer_pkg.sv
// Shared constants for the text writer: grid defaults, control codes, FSM states.
package vga_text_writer_pkg;
  localparam int DEF_COLS     = 80;
  localparam int DEF_ROWS     = 32;
  localparam int DEF_COL_BITS = 7;
  localparam int DEF_ROW_BITS = 5;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [1:0] {IDLE, PUT, CLR_ROW, CLR_ALL} state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction
endpackage

// File: rtl/vga_text_writer_cursor.sv
// Cursor row/column counters; column wraps into the next row, last row wraps to 0.
module vga_cursor #(
  parameter int COLS     = 80,
  parameter int ROWS     = 32,
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                newline,
  input  logic                cr,
  input  logic                back,
  input  logic                home,
  output logic [ROW_BITS-1:0] row,
  output logic [COL_BITS-1:0] col,
  output logic                last_col,
  output logic                last_row
);
  assign last_col = (col == COL_BITS'(COLS - 1));
  assign last_row = (row == ROW_BITS'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst || home) begin
      row <= '0;
      col <= '0;
    end else if (newline || (inc && last_col)) begin
      col <= '0;
      row <= last_row ? '0 : row + 1'b1;
    end else if (inc) begin
      col <= col + 1'b1;
    end else if (cr) begin
      col <= '0;
    end else if (back && (col != '0)) begin
      col <= col - 1'b1;
    end
  end
endmodule

// File: rtl/vga_text_writer.sv
// CPU character stream to text-RAM writer: prints, handles LF/CR/BS/FF, clears rows on wrap.
module vga_text_writer
  import vga_text_writer_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ROWS     = DEF_ROWS,
  parameter int COL_BITS = DEF_COL_BITS,
  parameter int ROW_BITS = DEF_ROW_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bus_we,
  input  logic [7:0]          bus_data,
  output logic                bus_ready,
  output logic [31:0]         waddr,
  output logic [7:0]          wdata,
  output logic                selRW,
  output logic [ROW_BITS-1:0] cur_row,
  output logic [COL_BITS-1:0] cur_col
);
  state_t              state, state_nx;
  logic [ROW_BITS-1:0] wr_row, wr_row_nx;
  logic [COL_BITS-1:0] wr_col, wr_col_nx;
  logic [7:0]          wd, wd_nx;
  logic                put_inc, put_inc_nx;
  logic                c_inc, c_nl, c_cr, c_back, c_home;
  logic                last_col, last_row;
  logic                wr_last_col;

  vga_cursor #(.COLS(COLS), .ROWS(ROWS), .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS)) u_cursor (
    .clk(clk), .rst(rst), .inc(c_inc), .newline(c_nl), .cr(c_cr), .back(c_back), .home(c_home),
    .row(cur_row), .col(cur_col), .last_col(last_col), .last_row(last_row)
  );

  assign wr_last_col = (wr_col == COL_BITS'(COLS - 1));
  assign bus_ready   = (state == IDLE);
  assign selRW       = (state != IDLE);
  assign waddr       = 32'({wr_row, wr_col});
  assign wdata       = wd;

  always_comb begin
    state_nx   = state;
    wr_row_nx  = wr_row;
    wr_col_nx  = wr_col;
    wd_nx      = wd;
    put_inc_nx = put_inc;
    c_inc      = 1'b0;
    c_nl       = 1'b0;
    c_cr       = 1'b0;
    c_back     = 1'b0;
    c_home     = 1'b0;
    case (state)
      IDLE: begin
        if (bus_we) begin
          if (is_printable(bus_data)) begin
            wr_row_nx  = cur_row;
            wr_col_nx  = cur_col;
            wd_nx      = bus_data;
            put_inc_nx = 1'b1;
            state_nx   = PUT;
          end else begin
            case (bus_data)
              CH_LF: begin
                c_nl = 1'b1;
                // Wrapping back to row 0 reuses stale text, so blank it first
                if (last_row) begin
                  wr_row_nx = '0;
                  wr_col_nx = '0;
                  wd_nx     = CH_SP;
                  state_nx  = CLR_ROW;
                end
              end
              CH_CR: c_cr = 1'b1;
              CH_BS: begin
                if (cur_col != '0) begin
                  c_back     = 1'b1;
                  wr_row_nx  = cur_row;
                  wr_col_nx  = cur_col - 1'b1;
                  wd_nx      = CH_SP;
                  put_inc_nx = 1'b0;
                  state_nx   = PUT;
                end
              end
              CH_FF: begin
                c_home    = 1'b1;
                wr_row_nx = '0;
                wr_col_nx = '0;
                wd_nx     = CH_SP;
                state_nx  = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      PUT: begin
        c_inc = put_inc;
        if (put_inc && last_col && last_row) begin
          wr_row_nx = '0;
          wr_col_nx = '0;
          wd_nx     = CH_SP;
          state_nx  = CLR_ROW;
        end else begin
          state_nx = IDLE;
        end
      end
      CLR_ROW: begin
        if (wr_last_col) state_nx = IDLE;
        else             wr_col_nx = wr_col + 1'b1;
      end
      CLR_ALL: begin
        if (wr_last_col) begin
          if (wr_row == ROW_BITS'(ROWS - 1)) begin
            state_nx = IDLE;
          end else begin
            wr_row_nx = wr_row + 1'b1;
            wr_col_nx = '0;
          end
        end else begin
          wr_col_nx = wr_col + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_row  <= '0;
      wr_col  <= '0;
      wd      <= CH_SP;
      put_inc <= 1'b0;
    end else begin
      state   <= state_nx;
      wr_row  <= wr_row_nx;
      wr_col  <= wr_col_nx;
      wd      <= wd_nx;
      put_inc <= put_inc_nx;
    end
  end
endmodule

// File: tb/tb_vga_text_writer.sv
// Randomized + directed bench for vga_text_writer against a screen-level write/cursor model.
module tb_vga_text_writer;
  localparam int COLS = 80, ROWS = 32, COL_BITS = 7, ROW_BITS = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                bus_we = 1'b0;
  logic [7:0]          bus_data = 8'h00;
  logic                bus_ready;
  logic [31:0]         waddr;
  logic [7:0]          wdata;
  logic                selRW;
  logic [ROW_BITS-1:0] cur_row;
  logic [COL_BITS-1:0] cur_col;

  vga_text_writer #(.COLS(COLS), .ROWS(ROWS), .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS)) dut (
    .clk(clk), .rst(rst), .bus_we(bus_we), .bus_data(bus_data), .bus_ready(bus_ready),
    .waddr(waddr), .wdata(wdata), .selRW(selRW), .cur_row(cur_row), .cur_col(cur_col)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  int  m_row = 0, m_col = 0;
  int  tests = 0, fails = 0;
  int  pulse_cnt = 0;
  int  cyc = 0;
  int  rst_at_pulse = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_wr(input int r, input int c, input int d);
    wr_t e;
    e.addr = r * (1 << COL_BITS) + c;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic advance_row();
    m_row++;
    if (m_row == ROWS) begin
      m_row = 0;
      for (int c = 0; c < COLS; c++) push_wr(0, c, 32'h20);
    end
  endtask

  task automatic model_char(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      push_wr(m_row, m_col, int'(ch));
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        advance_row();
      end
    end else if (ch == 8'h0A) begin
      m_col = 0;
      advance_row();
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_wr(m_row, m_col, 32'h20);
      end
    end else if (ch == 8'h0C) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) push_wr(r, c, 32'h20);
      m_row = 0;
      m_col = 0;
    end
  endtask

  // One cycle: observe outputs at the falling edge, then drive the next inputs.
  task automatic step(input logic we, input logic [7:0] data, input logic rst_i);
    wr_t e;
    logic r;
    @(negedge clk);
    cyc++;
    if (cyc > 95000) begin
      $display("FAIL cycle_budget got=%0d exp<95000", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $finish;
    end
    if (selRW) begin
      pulse_cnt++;
      check("ready_while_busy", 32'(bus_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(waddr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("waddr", waddr, e.addr);
        check("wdata", 32'(wdata), e.data);
      end
    end else if (bus_ready) begin
      check("pending_writes", exp_q.size(), 32'd0);
      check("cur_row", 32'(cur_row), m_row);
      check("cur_col", 32'(cur_col), m_col);
    end
    r = rst_i;
    if (rst_at_pulse > 0 && pulse_cnt == rst_at_pulse) begin
      r = 1'b1;
      rst_at_pulse = 0;
    end
    rst      = r;
    bus_we   = we;
    bus_data = data;
    if (r) begin
      exp_q.delete();
      m_row = 0;
      m_col = 0;
    end else if (we && bus_ready) begin
      model_char(data);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!bus_ready || exp_q.size() != 0) && n < 3000) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    if (n >= 3000) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [7:0] ch);
    wait_idle();
    step(1'b1, ch, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    wait_idle();
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check("rst_ready", 32'(bus_ready), 32'd1);
    check("rst_selrw", 32'(selRW), 32'd0);
    check("rst_waddr", waddr, 32'd0);
    check("rst_wdata", 32'(wdata), 32'h20);
    check("rst_cursor", 32'({cur_row, cur_col}), 32'd0);
  endtask

  function automatic logic [7:0] rand_char();
    int p = $urandom_range(0, 99);
    if (p < 50) return 8'($urandom_range(32'h20, 32'h7E));
    if (p < 72) return 8'h0A;
    if (p < 80) return 8'h0D;
    if (p < 91) return 8'h08;
    if (p < 92) return 8'h0C;
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'h1B;
      2:       return 8'h7F;
      default: return 8'h80 | 8'($urandom_range(0, 127));
    endcase
  endfunction

  initial begin
    do_reset();

    // Single printable character
    pulse_cnt = 0;
    send(8'h41);
    check("A_pulses", pulse_cnt, 32'd1);
    check("A_waddr", waddr, 32'h000);
    check("A_cursor_col", 32'(cur_col), 32'd1);

    // Full row of 'B' wraps the column
    do_reset();
    pulse_cnt = 0;
    for (int i = 0; i < COLS; i++) send(8'h42);
    check("B_pulses", pulse_cnt, 32'd80);
    check("B_last_waddr", waddr, 32'h04F);
    check("B_cursor", 32'({cur_row, cur_col}), 32'({5'd1, 7'd0}));

    // LF on the last row wraps and clears row 0
    do_reset();
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h78);
    pulse_cnt = 0;
    send(8'h0A);
    check("lf_wrap_pulses", pulse_cnt, 32'd80);
    check("lf_wrap_cursor", 32'({cur_row, cur_col}), 32'd0);

    // Backspace mid-row and at column 0
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h0A);
    for (int i = 0; i < 10; i++) send(8'h79);
    pulse_cnt = 0;
    send(8'h08);
    check("bs_pulses", pulse_cnt, 32'd1);
    check("bs_waddr", waddr, 32'h189);
    send(8'h0D);
    pulse_cnt = 0;
    send(8'h08);
    check("bs_col0_pulses", pulse_cnt, 32'd0);

    // Form feed, then a second one aborted by reset after 100 pulses
    pulse_cnt = 0;
    send(8'h0C);
    check("ff_pulses", pulse_cnt, 32'd2560);
    send(8'h41);
    pulse_cnt = 0;
    rst_at_pulse = 100;
    step(1'b1, 8'h0C, 1'b0);
    for (int i = 0; i < 150; i++) step(1'b0, 8'h00, 1'b0);
    check("ff_abort_pulses", pulse_cnt, 32'd100);
    check("ff_abort_cursor", 32'({cur_row, cur_col}), 32'd0);
    check("ff_abort_wdata", 32'(wdata), 32'h20);

    // bus_we held high with 'C' across a row clear
    do_reset();
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    pulse_cnt = 0;
    step(1'b1, 8'h0A, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, 8'h43, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    wait_idle();
    check("hold_C_cursor_row", 32'(cur_row), 32'd0);
    check("hold_C_pulses_gt80", 32'(pulse_cnt > 80 && pulse_cnt < 100), 32'd1);

    // Randomized character stream, sometimes with back-to-back strobes
    do_reset();
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step(1'b1, rand_char(), 1'b0);
      end else begin
        send(rand_char());
      end
    end
    step(1'b0, 8'h00, 1'b0);
    wait_idle();
    step(1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
